reorder_buffer: RTL

- 16-entry circular reorder buffer for the Tomasulo core.
- Allocates a ROB tag per decoded instruction; that tag is the update_ROB_pos consumed by the reservation station and load/store buffer.
- Captures CDB results (val_flag/val_idx/val), serves operand lookups at issue, and retires in program order to the register file.
- On retirement of a mispredicted branch, flushes the pipeline and redirects the PC.

---
 rtl/reorder_buffer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: tag allocation, CDB capture, operand lookup, in-order retire, mispredict flush.
// Optional ROB_BYPASS_EN: operand lookup also forwards the current-cycle CDB broadcast.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_branch,
  input  logic             issue_pred_taken,
  input  logic [31:0]      issue_alt_pc,
  output logic [TAG_W-1:0] issue_pos,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_pos,
  input  logic [31:0]      cdb_val,
  input  logic [TAG_W-1:0] q1_pos,
  input  logic [TAG_W-1:0] q2_pos,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [TAG_W-1:0] commit_pos,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [DEPTH-1:0] busy, ready_q, busy_nx, ready_nx;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [31:0]      alt_q  [DEPTH];
  logic             br_q   [DEPTH];
  logic             pred_q [DEPTH];

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             commit_now, flush_now, issue_now, cdb_now;

  assign full       = (count == CNT_FULL);
  assign issue_pos  = tail;
  assign commit_now = rdy && (count != '0) && ready_q[head];
  assign flush_now  = commit_now && br_q[head] && (val_q[head][0] != pred_q[head]);
  assign issue_now  = rdy && issue_valid && !full && !flush_now;
  assign cdb_now    = rdy && cdb_valid && busy[cdb_pos];

  // Flush wins over every per-entry update so nothing younger survives a mispredict.
  always_comb begin
    busy_nx  = busy;
    ready_nx = ready_q;
    if (cdb_now) ready_nx[cdb_pos] = 1'b1;
    if (issue_now) begin
      busy_nx[tail]  = 1'b1;
      ready_nx[tail] = 1'b0;
    end
    if (commit_now) begin
      busy_nx[head]  = 1'b0;
      ready_nx[head] = 1'b0;
    end
    if (flush_now) begin
      busy_nx  = '0;
      ready_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      ready_q <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      busy    <= busy_nx;
      ready_q <= ready_nx;
      if (flush_now) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit_now) head <= head + TAG_ONE;
        if (issue_now)  tail <= tail + TAG_ONE;
        if (issue_now && !commit_now)      count <= count + CNT_ONE;
        else if (commit_now && !issue_now) count <= count - CNT_ONE;
      end
    end
  end

  // Payloads are qualified by busy/ready, so they need no reset.
  always_ff @(posedge clk) begin
    if (issue_now) begin
      rd_q[tail]   <= issue_rd;
      br_q[tail]   <= issue_is_branch;
      pred_q[tail] <= issue_pred_taken;
      alt_q[tail]  <= issue_alt_pc;
    end
    if (cdb_now) val_q[cdb_pos] <= cdb_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_val   <= '0;
      commit_pos   <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= commit_now;
      flush        <= flush_now;
      if (commit_now) begin
        commit_rd  <= flush_now ? 5'd0 : rd_q[head];
        commit_val <= val_q[head];
        commit_pos <= head;
      end
      if (flush_now) flush_pc <= alt_q[head];
    end
  end

  always_comb begin
    q1_ready = busy[q1_pos] && ready_q[q1_pos];
    q1_val   = val_q[q1_pos];
    q2_ready = busy[q2_pos] && ready_q[q2_pos];
    q2_val   = val_q[q2_pos];
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_pos == q1_pos) && busy[q1_pos]) begin
      q1_ready = 1'b1;
      q1_val   = cdb_val;
    end
    if (cdb_valid && (cdb_pos == q2_pos) && busy[q2_pos]) begin
      q2_ready = 1'b1;
      q2_val   = cdb_val;
    end
`else
`endif
  end

endmodule
